// File: rtl/mult_dot_accum.sv
// Dot-product accumulator downstream of the 4x4 multiplier core.
// Sums a group of 8-bit products and presents the sum on a valid/ready output.
module mult_dot_accum #(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned MAX_TERMS = 16,
  parameter bit          SAT       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_close;
  logic               w_out_hs;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_add;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_ovf_add;

  // Beat datapath: one extra sum bit exposes overflow for the saturate/wrap choice.
  assign w_accept  = in_valid & r_in_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(prod_in);
  assign w_acc_add = (w_sum[ACC_W] && SAT) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_ovf_add = r_ovf | w_sum[ACC_W];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_close   = in_last | (w_cnt_inc == CNT_W'(MAX_TERMS));

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_acc_add;
          w_cnt_nxt   = w_cnt_inc;
          w_ovf_nxt   = w_ovf_add;
          w_state_nxt = w_close ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (w_out_hs) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake flags follow the next state, so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt != HOLD);
      r_out_valid <= (w_state_nxt == HOLD);
      if (w_accept && w_close) begin
        r_out_data  <= w_acc_add;
        r_out_count <= w_cnt_inc;
        r_out_ovf   <= w_ovf_add;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mult_dot_accum.sv
// Bench for mult_dot_accum: three configurations share one stimulus stream,
// results are scored against a behavioural model through per-instance queues.
module tb_mult_dot_accum;

  typedef struct {
    int data;
    int cnt;
    int ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  prod_in;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [15:0] d0;
  logic [9:0]  d1, d2;
  logic [7:0]  c0, c1, c2;
  logic        f0, f1, f2;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[3][$];
  int   m_acc[3];
  int   m_ovf[3];
  int   m_cnt;

  always #5 clk = ~clk;

  mult_dot_accum #(.ACC_W(16), .MAX_TERMS(16), .SAT(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0), .out_data(d0), .out_count(c0), .out_ovf(f0), .out_valid(ov0),
    .out_ready(out_ready));

  mult_dot_accum #(.ACC_W(10), .MAX_TERMS(16), .SAT(1'b1)) u_w10_sat (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1), .out_data(d1), .out_count(c1), .out_ovf(f1), .out_valid(ov1),
    .out_ready(out_ready));

  mult_dot_accum #(.ACC_W(10), .MAX_TERMS(16), .SAT(1'b0)) u_w10_wrap (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy2), .out_data(d2), .out_count(c2), .out_ovf(f2), .out_valid(ov2),
    .out_ready(out_ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_accept(input int p, input bit last);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      int w   = (k == 0) ? 16 : 10;
      int lim = 1 << w;
      int s   = m_acc[k] + p;
      if (s >= lim) begin
        m_ovf[k] = 1;
        s = (k == 2) ? s - lim : lim - 1;
      end
      m_acc[k] = s;
    end
    m_cnt++;
    if (last || m_cnt == 16) begin
      for (int k = 0; k < 3; k++) begin
        e.data = m_acc[k];
        e.cnt  = m_cnt;
        e.ovf  = m_ovf[k];
        sb[k].push_back(e);
      end
      model_clear();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat that the model expects to be accepted this cycle.
  task automatic send(input int p, input bit last);
    prod_in  = 8'(p);
    in_last  = last;
    in_valid = 1'b1;
    check("in_ready_on_beat", {29'd0, rdy0, rdy1, rdy2}, 32'd7);
    model_accept(p, last);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d,
                     input logic [7:0] c, input logic o);
    exp_t e;
    if (v) begin
      if (sb[k].size() == 0) begin
        check($sformatf("unexpected_result%0d", k), 32'd1, 32'd0);
      end else begin
        e = sb[k].pop_front();
        check($sformatf("out_data%0d", k), d, 32'(e.data));
        check($sformatf("out_count%0d", k), {24'd0, c}, 32'(e.cnt));
        check($sformatf("out_ovf%0d", k), {31'd0, o}, 32'(e.ovf));
      end
    end
  endtask

  // Score each result exactly once, on the cycle its handshake completes.
  always @(negedge clk) begin
    if (out_ready) begin
      mon(0, ov0, {16'd0, d0}, c0, f0);
      mon(1, ov1, {22'd0, d1}, c1, f1);
      mon(2, ov2, {22'd0, d2}, c2, f2);
    end
  end

  initial begin
    rst_n     = 1'b0;
    prod_in   = 8'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
    check("rst_out_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
    check("rst_out_data", {16'd0, d0}, 32'd0);
    check("rst_out_count", {24'd0, c0}, 32'd0);
    check("rst_out_ovf", {31'd0, f0}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {31'd0, rdy0}, 32'd1);

    // Four 15*15 products, latency and in_ready recovery.
    out_ready = 1'b1;
    repeat (3) send(225, 1'b0);
    send(225, 1'b1);
    check("t1_out_valid", {29'd0, ov0, ov1, ov2}, 32'd7);
    check("t1_in_ready_low", {31'd0, rdy0}, 32'd0);
    check("t1_data_const", {16'd0, d0}, 32'd900);
    tick();
    check("t1_valid_drop", {31'd0, ov0}, 32'd0);
    check("t1_in_ready_back", {31'd0, rdy0}, 32'd1);

    // Five 225s: overflows the 10-bit instances.
    repeat (4) send(225, 1'b0);
    send(225, 1'b1);
    check("t2_sat_const", {22'd0, d1}, 32'd1023);
    check("t2_wrap_const", {22'd0, d2}, 32'd101);
    check("t2_ovf_const", {29'd0, f0, f1, f2}, 32'd3);
    check("t2_count_const", {24'd0, c1}, 32'd5);
    tick();

    // Auto-close at MAX_TERMS; the 17th beat waits for the handshake.
    out_ready = 1'b0;
    repeat (16) send(1, 1'b0);
    check("t3_autoclose_valid", {31'd0, ov0}, 32'd1);
    check("t3_count_const", {24'd0, c0}, 32'd16);
    prod_in  = 8'd5;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("t3_blocked_ready", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_valid_drop", {31'd0, ov0}, 32'd0);
    send(5, 1'b1);
    check("t3_new_group_count", {24'd0, c0}, 32'd1);
    tick();

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    send(42, 1'b1);
    prod_in  = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_low", {31'd0, rdy0}, 32'd0);
      check("t4_valid_held", {31'd0, ov0}, 32'd1);
      check("t4_data_held", {16'd0, d0}, 32'd42);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t4_valid_drop", {31'd0, ov0}, 32'd0);
    check("t4_in_ready_back", {31'd0, rdy0}, 32'd1);

    // Reset mid-group discards the partial sum.
    repeat (3) send(100, 1'b0);
    rst_n = 1'b0;
    model_clear();
    tick();
    check("t5_rst_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
    check("t5_rst_ready", {31'd0, rdy0}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5_post_rst_valid", {31'd0, ov0}, 32'd0);
    send(7, 1'b1);
    check("t5_data_const", {16'd0, d0}, 32'd7);
    tick();

    // Idle gaps inside a group.
    send(10, 1'b0);
    repeat (3) tick();
    send(20, 1'b0);
    send(30, 1'b1);
    check("t6_data_const", {16'd0, d0}, 32'd60);
    repeat (3) tick();

    for (int k = 0; k < 3; k++)
      check($sformatf("sb_empty%0d", k), 32'(sb[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Sequential stage directly downstream of the 4x4 combinational multiplier core (ports x, y, o[7:0]).
- Consumes one 8-bit product per accepted beat and accumulates a group of products into a dot-product sum.
- Presents each completed sum on a valid/ready output port.
- Provides the first clocked boundary after the multiplier tree and its prefix adder.

Parameters:
- ACC_W, 16, accumulator and result width in bits; legal range 8..32.
- MAX_TERMS, 16, maximum number of products per group; the group closes automatically when this count is reached; legal range 1..255.
- SAT, 1, overflow policy: 1 saturates to all-ones, 0 wraps modulo 2^ACC_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- prod_in  input  8  unsigned product from the multiplier output o[7:0].
- in_valid  input  1  prod_in and in_last are valid this cycle.
- in_last  input  1  the current beat is the final product of the group.
- in_ready  output  1  the block can accept a beat this cycle.
- out_data  output  ACC_W  completed group sum.
- out_count  output  8  number of products in the completed group (1..MAX_TERMS).
- out_ovf  output  1  at least one overflow occurred in this group.
- out_valid  output  1  out_data, out_count and out_ovf are valid.
- out_ready  input  1  the consumer accepts the result.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; acc, cnt and ovf cleared.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0, in_ready=0 during the reset cycle.
  - Reset mid-group or mid-hold discards all partial state. No result is emitted.
- States:
  - IDLE: no beats accepted yet in the current group.
  - ACCUM: at least one beat accepted, group still open.
  - HOLD: result presented on the output, waiting for out_ready.
- in_ready is 1 in IDLE and ACCUM, and 0 in HOLD and during reset. It is a registered output with no combinational path from out_ready.
- Accept: in_valid & in_ready at a clock edge. On accept:
  - sum = acc + zero-extend(prod_in), computed at ACC_W+1 bits.
  - If sum >= 2^ACC_W, ovf is set (sticky within the group). acc takes 2^ACC_W-1 when SAT=1, or sum mod 2^ACC_W when SAT=0.
  - Otherwise acc = sum.
  - cnt increments by 1.
- Group close: on an accept with in_last=1 or with cnt+1 == MAX_TERMS, the next state is HOLD.
  - In the following cycle, out_valid=1, out_data is the sum including that beat, out_count=cnt+1, out_ovf is the final ovf.
  - Latency from the closing accept to out_valid is 1 cycle.
- An accept that does not close the group moves IDLE->ACCUM, or stays in ACCUM.
- HOLD:
  - out_data, out_count and out_ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid drops the next cycle; acc, cnt and ovf clear; state goes to IDLE; in_ready rises the next cycle.
  - Output handshake and input accept never occur in the same cycle.
- out_data, out_count and out_ovf are registered. They keep their last values after the handshake until the next result; the consumer only samples them while out_valid=1.
- in_valid=0 in any state: no state change.
- in_last is ignored when in_valid=0.
- A beat with prod_in=0 counts as a term.
- A single-beat group (in_last on the first accept) is legal: out_count=1.
- With MAX_TERMS=1, every accepted beat closes its group.

Test Plan:
- ACC_W=16: four beats of prod_in=225 (15*15), in_last on the 4th, out_ready=1 -> one cycle later out_valid=1, out_data=900 (0x0384), out_count=4, out_ovf=0; in_ready=1 two cycles after the last accept.
- ACC_W=10, SAT=1: five beats of 225 with last on the 5th -> out_data=1023, out_ovf=1, out_count=5. The same test with SAT=0 -> out_data=101 (1125-1024), out_ovf=1.
- MAX_TERMS=16, in_last never asserted, 16 beats of prod_in=1 -> group closes after the 16th beat with out_data=16, out_count=16. The 17th beat is not accepted until after the output handshake, and starts a new group.
- Backpressure: complete a group of one beat of prod_in=42, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, out_data=42 and out_valid=1 stable. Raise out_ready -> out_valid=0 and in_ready=1 the next cycle.
- Reset mid-group: accept 3 beats of 100, then rst_n=0 for one cycle -> out_valid never rises. Next group of one beat of 7 with last -> out_data=7, out_count=1, out_ovf=0.
- Idle gaps: beats 10, gap of 3 cycles with in_valid=0, 20, last=30 -> out_data=60, out_count=3.
